// File: rtl/instr_reg_seq.sv
// Instruction register sequencer: captures an opcode byte plus up to MAX_EXT
// big-endian extension bytes, then presents the opcode to the controller and
// the assembled operand to the bus on demand.
module instr_reg_seq #(
  parameter int DATA_W  = 8,
  parameter int OPC_W   = 4,
  parameter int MAX_EXT = 2,
  localparam int OPND_W = (DATA_W - OPC_W) + MAX_EXT * DATA_W,
  localparam int CW     = (MAX_EXT < 2) ? 1 : $clog2(MAX_EXT + 1)
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic [DATA_W-1:0] data_in,
  input  logic              Li_bar,
  input  logic              Ei_bar,
  input  logic [CW-1:0]     ext_cnt,
  output logic [OPC_W-1:0]  instr_out,
  output logic [OPND_W-1:0] data_out,
  output logic              oe,
  output logic              ir_valid,
  output logic              ir_busy,
  output logic              ir_err
);

  // Operand bits carried by the opcode byte itself.
  localparam int LOW_W = DATA_W - OPC_W;
  localparam logic [CW-1:0] MAX_EXT_C = CW'(MAX_EXT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_EXT,
    S_FULL
  } state_t;

  state_t              state;
  logic [OPC_W-1:0]    opcode;
  logic [OPND_W-1:0]   operand;
  logic [CW-1:0]       rem;

  logic                opc_load;
  logic                ext_load;
  logic                cnt_over;
  logic [CW-1:0]       cnt_clamped;
  logic                err_next;
  logic [OPND_W-1:0]   load_opnd;
  logic [OPND_W-1:0]   ext_opnd;

  // Shift-in of an extension byte; with no extensions the path is never used.
  if (MAX_EXT > 0) begin : g_ext
    assign ext_opnd = {operand[OPND_W-DATA_W-1:0], data_in};
  end else begin : g_noext
    assign ext_opnd = operand;
  end

  // Decode load type, clamp the extension count and flag protocol violations.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_opnd             = '0;
    load_opnd[LOW_W-1:0]  = data_in[LOW_W-1:0];
    opc_load              = !Li_bar && (state != S_EXT);
    ext_load              = !Li_bar && (state == S_EXT);
    cnt_over              = ext_cnt > MAX_EXT_C;
    cnt_clamped           = cnt_over ? MAX_EXT_C : ext_cnt;
    err_next              = (!Ei_bar && (state != S_FULL)) || (opc_load && cnt_over);
  end

  // Sequencer FSM with its registered status outputs.
  always_ff @(posedge CLK or negedge CLR_bar) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!CLR_bar) begin
      state    <= S_EMPTY;
      opcode   <= '0;
      operand  <= '0;
      rem      <= '0;
      ir_valid <= 1'b0;
      ir_busy  <= 1'b0;
      ir_err   <= 1'b0;
    end else begin
      ir_err <= err_next;
      if (opc_load) begin
        // A load in FULL overwrites the finished instruction in the same edge.
        opcode  <= data_in[DATA_W-1 -: OPC_W];
        operand <= load_opnd;
        rem     <= cnt_clamped;
        if (cnt_clamped == '0) begin
          state    <= S_FULL;
          ir_valid <= 1'b1;
          ir_busy  <= 1'b0;
        end else begin
          state    <= S_EXT;
          ir_valid <= 1'b0;
          ir_busy  <= 1'b1;
        end
      end else if (ext_load) begin
        operand <= ext_opnd;
        rem     <= rem - ONE_C;
        if (rem == ONE_C) begin
          state    <= S_FULL;
          ir_valid <= 1'b1;
          ir_busy  <= 1'b0;
        end
      end
    end
  end

  // Bus drive: operand only while enabled in FULL, otherwise zero.
  always_comb begin
    oe       = !Ei_bar && (state == S_FULL);
    data_out = oe ? operand : '0;
  end

  assign instr_out = opcode;

endmodule

// File: tb/tb_instr_reg_seq.sv
// Bench for instr_reg_seq at DATA_W=8, OPC_W=4, MAX_EXT=2 (20-bit operand).
module tb_instr_reg_seq;

  logic        tb_clk;
  logic        CLR_bar;
  logic [7:0]  data_in;
  logic        Li_bar;
  logic        Ei_bar;
  logic [1:0]  ext_cnt;
  logic [3:0]  instr_out;
  logic [19:0] data_out;
  logic        oe;
  logic        ir_valid;
  logic        ir_busy;
  logic        ir_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  opc;
    logic [19:0] opnd;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  m_opc;
  logic [19:0] m_opnd;
  int          m_rem;

  instr_reg_seq dut (
    .CLK       (tb_clk),
    .CLR_bar   (CLR_bar),
    .data_in   (data_in),
    .Li_bar    (Li_bar),
    .Ei_bar    (Ei_bar),
    .ext_cnt   (ext_cnt),
    .instr_out (instr_out),
    .data_out  (data_out),
    .oe        (oe),
    .ir_valid  (ir_valid),
    .ir_busy   (ir_busy),
    .ir_err    (ir_err)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Drive inputs on the falling edge; return 1 ns later for sampling.
  task automatic drive(input logic [7:0] d, input logic li, input logic ei,
                       input logic [1:0] cnt);
    @(negedge tb_clk);
    data_in = d;
    Li_bar  = li;
    Ei_bar  = ei;
    ext_cnt = cnt;
    #1;
  endtask

  // Reference model: an opcode byte starts an instruction.
  task automatic model_op(input logic [7:0] d, input logic [1:0] cnt);
    m_opc  = d[7:4];
    m_opnd = {16'h0000, d[3:0]};
    m_rem  = (cnt > 2) ? 2 : int'(cnt);
    if (m_rem == 0) sb.push_back('{opc: m_opc, opnd: m_opnd});
  endtask

  // Reference model: an extension byte shifts in big-endian.
  task automatic model_ext(input logic [7:0] d);
    m_opnd = {m_opnd[11:0], d};
    m_rem  = m_rem - 1;
    if (m_rem == 0) sb.push_back('{opc: m_opc, opnd: m_opnd});
  endtask

  // Enable the bus in FULL (optionally loading at the same time) and compare
  // against the oldest completed instruction.
  task automatic read_during(input logic [7:0] d, input logic li,
                             input logic [1:0] cnt, input string name);
    exp_t e;
    drive(d, li, 1'b0, cnt);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: no instruction expected but read attempted", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (instr_out !== e.opc) begin
        errors++;
        $display("FAIL %s instr_out: got %h expected %h", name, instr_out, e.opc);
      end
      checks++;
      if (data_out !== e.opnd) begin
        errors++;
        $display("FAIL %s data_out: got %h expected %h", name, data_out, e.opnd);
      end
    end
    checks++;
    if ({oe, ir_valid, ir_busy, ir_err} !== 4'b1100) begin
      errors++;
      $display("FAIL %s flags oe/valid/busy/err: got %b expected 1100", name,
               {oe, ir_valid, ir_busy, ir_err});
    end
    if (!li) model_op(d, cnt);
  endtask

  task automatic read_check(input string name);
    read_during(8'h00, 1'b1, 2'd0, name);
  endtask

  task automatic test_reset();
    CLR_bar = 1'b0;
    data_in = 8'h00;
    Li_bar  = 1'b1;
    Ei_bar  = 1'b1;
    ext_cnt = 2'd0;
    #3;
    checks++;
    if ({instr_out, data_out, oe, ir_valid, ir_busy, ir_err} !== 28'h0) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 0",
               {instr_out, data_out, oe, ir_valid, ir_busy, ir_err});
    end
    @(negedge tb_clk);
    CLR_bar = 1'b1;
    // Enable while EMPTY: bus stays zero, error pulses one cycle later.
    drive(8'h00, 1'b1, 1'b0, 2'd0);
    checks++;
    if ({oe, data_out} !== 21'h0) begin
      errors++;
      $display("FAIL empty_enable bus: got %h expected 0", {oe, data_out});
    end
    drive(8'h00, 1'b1, 1'b1, 2'd0);
    checks++;
    if (ir_err !== 1'b1) begin
      errors++;
      $display("FAIL empty_enable err_pulse: got %b expected 1", ir_err);
    end
    drive(8'h00, 1'b1, 1'b1, 2'd0);
    checks++;
    if (ir_err !== 1'b0) begin
      errors++;
      $display("FAIL empty_enable err_clear: got %b expected 0", ir_err);
    end
  endtask

  task automatic test_single_byte();
    drive(8'h1E, 1'b0, 1'b1, 2'd0);
    model_op(8'h1E, 2'd0);
    read_check("single_byte");
  endtask

  task automatic test_two_ext();
    drive(8'h3A, 1'b0, 1'b1, 2'd2);
    model_op(8'h3A, 2'd2);
    drive(8'h12, 1'b0, 1'b1, 2'd0);
    model_ext(8'h12);
    checks++;
    if ({instr_out, ir_busy, ir_valid} !== {4'h3, 2'b10}) begin
      errors++;
      $display("FAIL two_ext first_busy instr/busy/valid: got %h expected %h",
               {instr_out, ir_busy, ir_valid}, {4'h3, 2'b10});
    end
    drive(8'h34, 1'b0, 1'b1, 2'd0);
    model_ext(8'h34);
    checks++;
    if ({instr_out, ir_busy, ir_valid} !== {4'h3, 2'b10}) begin
      errors++;
      $display("FAIL two_ext second_busy instr/busy/valid: got %h expected %h",
               {instr_out, ir_busy, ir_valid}, {4'h3, 2'b10});
    end
    read_check("two_ext");
  endtask

  task automatic test_early_enable();
    drive(8'h3A, 1'b0, 1'b1, 2'd2);
    model_op(8'h3A, 2'd2);
    drive(8'h12, 1'b0, 1'b0, 2'd0);
    model_ext(8'h12);
    checks++;
    if ({oe, data_out} !== 21'h0) begin
      errors++;
      $display("FAIL early_enable bus: got %h expected 0", {oe, data_out});
    end
    drive(8'h34, 1'b0, 1'b1, 2'd0);
    model_ext(8'h34);
    checks++;
    if (ir_err !== 1'b1) begin
      errors++;
      $display("FAIL early_enable err_pulse: got %b expected 1", ir_err);
    end
    read_check("early_enable");
  endtask

  task automatic test_back_to_back();
    drive(8'h1E, 1'b0, 1'b1, 2'd0);
    model_op(8'h1E, 2'd0);
    read_during(8'h25, 1'b0, 2'd0, "back_to_back_old");
    read_check("back_to_back_new");
  endtask

  task automatic test_reset_mid_ext();
    drive(8'h3A, 1'b0, 1'b1, 2'd2);
    drive(8'h12, 1'b0, 1'b1, 2'd0);
    drive(8'h00, 1'b1, 1'b1, 2'd0);
    checks++;
    if ({instr_out, ir_busy} !== {4'h3, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_ext pre instr/busy: got %h expected %h",
               {instr_out, ir_busy}, {4'h3, 1'b1});
    end
    #1;
    CLR_bar = 1'b0;
    #1;
    checks++;
    if ({instr_out, data_out, oe, ir_valid, ir_busy, ir_err} !== 28'h0) begin
      errors++;
      $display("FAIL reset_mid_ext async: got %h expected 0",
               {instr_out, data_out, oe, ir_valid, ir_busy, ir_err});
    end
    // A load strobe during reset must be ignored.
    data_in = 8'h55;
    Li_bar  = 1'b0;
    @(posedge tb_clk);
    #1;
    checks++;
    if ({instr_out, ir_valid, ir_busy} !== 6'h0) begin
      errors++;
      $display("FAIL reset_mid_ext held: got %h expected 0", {instr_out, ir_valid, ir_busy});
    end
    @(negedge tb_clk);
    Li_bar  = 1'b1;
    CLR_bar = 1'b1;
    sb.delete();
    m_rem = 0;
    drive(8'h40, 1'b0, 1'b1, 2'd0);
    model_op(8'h40, 2'd0);
    read_check("reset_mid_ext_reload");
  endtask

  task automatic test_clamp();
    drive(8'h5C, 1'b0, 1'b1, 2'd3);
    model_op(8'h5C, 2'd3);
    drive(8'h01, 1'b0, 1'b1, 2'd0);
    model_ext(8'h01);
    checks++;
    if ({ir_err, ir_busy} !== 2'b11) begin
      errors++;
      $display("FAIL clamp err/busy: got %b expected 11", {ir_err, ir_busy});
    end
    drive(8'h02, 1'b0, 1'b1, 2'd0);
    model_ext(8'h02);
    checks++;
    if ({ir_err, ir_busy} !== 2'b01) begin
      errors++;
      $display("FAIL clamp second err/busy: got %b expected 01", {ir_err, ir_busy});
    end
    read_check("clamp");
  endtask

  task automatic test_ext_wait();
    drive(8'h7F, 1'b0, 1'b1, 2'd1);
    model_op(8'h7F, 2'd1);
    for (int i = 0; i < 4; i++) drive(8'hEE, 1'b1, 1'b1, 2'd0);
    checks++;
    if ({ir_busy, ir_valid, instr_out} !== {2'b10, 4'h7}) begin
      errors++;
      $display("FAIL ext_wait hold busy/valid/instr: got %h expected %h",
               {ir_busy, ir_valid, instr_out}, {2'b10, 4'h7});
    end
    drive(8'hAB, 1'b0, 1'b1, 2'd0);
    model_ext(8'hAB);
    read_check("ext_wait");
  endtask

  initial begin
    m_rem = 0;
    test_reset();
    test_single_byte();
    test_two_ext();
    test_early_enable();
    test_back_to_back();
    test_reset_mid_ext();
    test_clamp();
    test_ext_wait();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
